// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder: one fetch in flight, valid/ready
// response handshake, plus a word-write port for preloading program memory.
module imem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_instr,
   output logic        resp_err,
   input  logic        resp_ready,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   logic [31:0] mem [DEPTH];

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_instr_q;
   logic        resp_err_q;

   logic [31:0] rd_addr_d;
   logic [29:0] rd_word_d;
   logic        rd_err_d;
   logic [31:0] rd_data_d;

   logic [29:0] wr_word_d;
   logic        wr_ok_d;

   // With LATENCY==1 the word is sampled on the accepting edge, so the live
   // request address is used in IDLE; otherwise the latched address.
   always_comb begin
      rd_addr_d = (state_q == IDLE) ? req_addr : addr_q;
      rd_word_d = 30'((rd_addr_d - BASE_ADDR) >> 2);
      rd_err_d  = (rd_addr_d[1:0] != 2'b00) || (rd_addr_d < BASE_ADDR) ||
                  ({2'b00, rd_word_d} >= 32'(DEPTH));
      rd_data_d = rd_err_d ? 32'h0 : mem[rd_word_d[DEPTH_LOG2-1:0]];
   end

   always_comb begin
      wr_word_d = 30'((wr_addr - BASE_ADDR) >> 2);
      wr_ok_d   = reset && wr_en && (wr_addr[1:0] == 2'b00) &&
                  (wr_addr >= BASE_ADDR) && ({2'b00, wr_word_d} < 32'(DEPTH));
   end

   // NOTE: the storage array has no reset so it maps onto RAM and keeps a
   // preloaded program across reset.
   always_ff @(posedge clock) begin
      if (wr_ok_d) begin
         mem[wr_word_d[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   // NOTE: every state register here uses <= so all of them update from the
   // same pre-edge values; that is also what makes a same-edge write return
   // the old word on RESP entry.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= 32'h0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_instr_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  addr_q      <= req_addr;
                  req_ready_q <= 1'b0;
                  if (LATENCY == 1) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_instr_q <= rd_data_d;
                     resp_err_q   <= rd_err_d;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= 4'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               req_ready_q  <= 1'b0;
               resp_valid_q <= 1'b0;
               if (cnt_q == 4'd0) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_instr_q <= rd_data_d;
                  resp_err_q   <= rd_err_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_instr = resp_instr_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (base 0 / latency 2, base 0x400 /
// latency 3 / 16 words) checked against a word-array reference model.
module tb_imem_responder;

   logic        clock;
   logic        reset;
   logic        req_valid  [2];
   logic [31:0] req_addr   [2];
   logic        req_ready  [2];
   logic        resp_valid [2];
   logic [31:0] resp_instr [2];
   logic        resp_err   [2];
   logic        resp_ready [2];
   logic        wr_en      [2];
   logic [31:0] wr_addr    [2];
   logic [31:0] wr_data    [2];

   logic [31:0] ref_mem [2][1024];
   int          n_pass;
   int          n_total;
   int          n_fail;

   imem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
      .resp_valid(resp_valid[0]), .resp_instr(resp_instr[0]), .resp_err(resp_err[0]),
      .resp_ready(resp_ready[0]),
      .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0])
   );

   imem_responder #(.DEPTH_LOG2(4), .LATENCY(3), .BASE_ADDR(32'h0000_0400)) u_dut_b (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
      .resp_valid(resp_valid[1]), .resp_instr(resp_instr[1]), .resp_err(resp_err[1]),
      .resp_ready(resp_ready[1]),
      .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? 32'h0000_0000 : 32'h0000_0400;
   endfunction

   function automatic int depth_of(input int d);
      return (d == 0) ? 1024 : 16;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   // A byte address is usable when word aligned, not below the base, and
   // inside the array; anything else is an error read / dropped write.
   function automatic logic addr_bad(input int d, input logic [31:0] a);
      logic [31:0] off;
      off = a - base_of(d);
      return (a % 4 != 0) || (a < base_of(d)) || ((off / 4) >= 32'(depth_of(d)));
   endfunction

   task automatic model_read(input int d, input logic [31:0] a,
                             output logic [31:0] data, output logic err);
      logic [31:0] idx;
      idx  = (a - base_of(d)) / 4;
      err  = addr_bad(d, a);
      data = err ? 32'h0 : ref_mem[d][idx[9:0]];
   endtask

   task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] v);
      logic [31:0] idx;
      idx = (a - base_of(d)) / 4;
      if (!addr_bad(d, a)) ref_mem[d][idx[9:0]] = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit later and any write
   // presented on that edge is folded into the model (unless in reset).
   task automatic step();
      @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (wr_en[d] && reset) model_write(d, wr_addr[d], wr_data[d]);
         wr_en[d] = 1'b0;
      end
   endtask

   task automatic write_word(input int d, input logic [31:0] a, input logic [31:0] v);
      wr_en[d]   = 1'b1;
      wr_addr[d] = a;
      wr_data[d] = v;
      step();
   endtask

   // Full fetch transaction. wr_cyc selects which edge (0 = accepting edge)
   // carries an extra write; the returned word is the memory content just
   // before edge LATENCY-1 counted from the accepting edge.
   task automatic fetch(input int d, input logic [31:0] a, input int stall,
                        input int wr_cyc, input logic [31:0] wa, input logic [31:0] wd,
                        output logic [31:0] got);
      logic [31:0] exp_d;
      logic        exp_e;
      int          lat;
      lat   = lat_of(d);
      exp_d = 32'h0;
      exp_e = 1'b0;
      chk("ready_idle", 32'(req_ready[d]), 32'h1);
      resp_ready[d] = (stall == 0);
      req_valid[d]  = 1'b1;
      req_addr[d]   = a;
      for (int c = 0; c < lat; c++) begin
         if (c == wr_cyc) begin
            wr_en[d]   = 1'b1;
            wr_addr[d] = wa;
            wr_data[d] = wd;
         end
         if (c == lat - 1) model_read(d, a, exp_d, exp_e);
         step();
         req_valid[d] = 1'b0;
         req_addr[d]  = $urandom;
         if (c < lat - 1) begin
            chk("wait_ready", 32'(req_ready[d]), 32'h0);
            chk("wait_valid", 32'(resp_valid[d]), 32'h0);
         end
      end
      chk("resp_valid", 32'(resp_valid[d]), 32'h1);
      chk("resp_instr", resp_instr[d], exp_d);
      chk("resp_err", 32'(resp_err[d]), 32'(exp_e));
      chk("resp_ready_low", 32'(req_ready[d]), 32'h0);
      got = resp_instr[d];
      for (int s = 0; s < stall; s++) begin
         req_valid[d]  = 1'b1;
         req_addr[d]   = $urandom;
         resp_ready[d] = 1'b0;
         step();
         chk("stall_valid", 32'(resp_valid[d]), 32'h1);
         chk("stall_instr", resp_instr[d], exp_d);
         chk("stall_err", 32'(resp_err[d]), 32'(exp_e));
         chk("stall_ready", 32'(req_ready[d]), 32'h0);
      end
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b1;
      step();
      chk("hs_valid", 32'(resp_valid[d]), 32'h0);
      chk("hs_ready", 32'(req_ready[d]), 32'h1);
      chk("hs_instr_hold", resp_instr[d], exp_d);
      chk("hs_err_hold", 32'(resp_err[d]), 32'(exp_e));
      resp_ready[d] = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr(input int d);
      int unsigned r;
      r = $urandom_range(0, 9);
      if (d == 0) begin
         if (r < 6)  return 32'($urandom_range(0, 1023)) * 4;
         if (r == 6) return 32'($urandom_range(0, 4095));
         if (r == 7) return 32'h1000 + 32'($urandom_range(0, 63)) * 4;
         if (r == 8) return 32'hFFFF_FFFC;
         return $urandom;
      end
      if (r < 6) return 32'h400 + 32'($urandom_range(0, 15)) * 4;
      if (r == 6) return 32'h3F0 + 32'($urandom_range(0, 3)) * 4;
      if (r == 7) return 32'h440 + 32'($urandom_range(0, 3)) * 4;
      return 32'h3F8 + 32'($urandom_range(0, 80));
   endfunction

   logic [31:0] got;
   logic [31:0] ra;

   initial begin
      n_pass  = 0;
      n_total = 0;
      n_fail  = 0;
      reset   = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_addr[d]   = 32'h0;
         resp_ready[d] = 1'b0;
         wr_en[d]      = 1'b0;
         wr_addr[d]    = 32'h0;
         wr_data[d]    = 32'h0;
         for (int i = 0; i < 1024; i++) ref_mem[d][i] = 32'h0;
      end

      // Reset held for two edges, then released.
      step();
      step();
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 32'(req_ready[d]), 32'h0);
         chk("rst_resp_valid", 32'(resp_valid[d]), 32'h0);
         chk("rst_resp_instr", resp_instr[d], 32'h0);
         chk("rst_resp_err", 32'(resp_err[d]), 32'h0);
      end
      reset = 1'b1;
      step();
      chk("post_rst_ready_a", 32'(req_ready[0]), 32'h1);
      chk("post_rst_ready_b", 32'(req_ready[1]), 32'h1);

      // Preload every word of both memories through the write port.
      for (int i = 0; i < 1024; i++) begin
         wr_en[0] = 1'b1; wr_addr[0] = 32'(i) * 4; wr_data[0] = $urandom;
         wr_en[1] = 1'b1; wr_addr[1] = 32'h400 + 32'(i % 16) * 4; wr_data[1] = $urandom;
         step();
      end
      write_word(0, 32'h0, 32'h2001_0005);
      write_word(0, 32'h4, 32'h2002_0007);
      write_word(0, 32'h8, 32'h0022_1820);
      write_word(0, 32'hC, 32'hac03_0000);

      // Basic fetch, back-to-back fetches, backpressure.
      fetch(0, 32'h0, 0, -1, 32'h0, 32'h0, got);
      chk("plan_w0", got, 32'h2001_0005);
      fetch(0, 32'h4, 0, -1, 32'h0, 32'h0, got);
      chk("plan_w1", got, 32'h2002_0007);
      fetch(0, 32'h8, 0, -1, 32'h0, 32'h0, got);
      chk("plan_w2", got, 32'h0022_1820);
      fetch(0, 32'hC, 0, -1, 32'h0, 32'h0, got);
      chk("plan_w3", got, 32'hac03_0000);
      fetch(0, 32'h4, 5, -1, 32'h0, 32'h0, got);
      chk("bp_w1", got, 32'h2002_0007);

      // Error responses on both instances.
      fetch(0, 32'h6, 0, -1, 32'h0, 32'h0, got);
      fetch(0, 32'h1000, 0, -1, 32'h0, 32'h0, got);
      fetch(0, 32'hFFFF_FFFC, 1, -1, 32'h0, 32'h0, got);
      fetch(1, 32'h0, 0, -1, 32'h0, 32'h0, got);
      fetch(1, 32'h3FC, 0, -1, 32'h0, 32'h0, got);
      fetch(1, 32'h440, 2, -1, 32'h0, 32'h0, got);
      fetch(1, 32'h43C, 0, -1, 32'h0, 32'h0, got);
      fetch(1, 32'h400, 0, -1, 32'h0, 32'h0, got);

      // Write/read ordering around a pending fetch.
      fetch(0, 32'h8, 0, 0, 32'h8, 32'hdead_beef, got);
      chk("wr_accept_edge", got, 32'hdead_beef);
      fetch(1, 32'h408, 0, 1, 32'h408, 32'hdead_beef, got);
      chk("wr_in_wait", got, 32'hdead_beef);
      fetch(0, 32'h8, 0, 1, 32'h8, 32'hcafe_f00d, got);
      chk("wr_resp_entry_old", got, 32'hdead_beef);
      fetch(0, 32'h8, 0, -1, 32'h0, 32'h0, got);
      chk("wr_resp_entry_new", got, 32'hcafe_f00d);
      write_word(0, 32'h9, 32'h1111_1111);
      write_word(0, 32'h1008, 32'h2222_2222);
      fetch(0, 32'h8, 0, -1, 32'h0, 32'h0, got);
      chk("wr_bad_ignored", got, 32'hcafe_f00d);
      write_word(1, 32'h3F8, 32'h3333_3333);
      fetch(1, 32'h438, 0, -1, 32'h0, 32'h0, got);

      // Reset during WAIT abandons the fetch and blocks writes.
      fetch(0, 32'h0, 0, -1, 32'h0, 32'h0, got);
      chk("ready_before_abort", 32'(req_ready[0]), 32'h1);
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h0;
      step();
      req_valid[0] = 1'b0;
      chk("abort_wait_ready", 32'(req_ready[0]), 32'h0);
      reset      = 1'b0;
      wr_en[0]   = 1'b1;
      wr_addr[0] = 32'h0;
      wr_data[0] = 32'h1234_5678;
      step();
      chk("abort_req_ready", 32'(req_ready[0]), 32'h0);
      chk("abort_resp_valid", 32'(resp_valid[0]), 32'h0);
      chk("abort_resp_instr", resp_instr[0], 32'h0);
      chk("abort_resp_err", 32'(resp_err[0]), 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("abort_no_resp", 32'(resp_valid[0]), 32'h0);
         chk("abort_ready", 32'(req_ready[0]), 32'h1);
      end
      fetch(0, 32'h0, 0, -1, 32'h0, 32'h0, got);
      chk("abort_wr_blocked", got, 32'h2001_0005);

      // Randomized mix of fetches, stalls and writes on both instances.
      for (int n = 0; n < 300; n++) begin
         int d;
         int wc;
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) begin
            write_word(d, rand_addr(d), $urandom);
         end else begin
            ra = rand_addr(d);
            wc = int'($urandom_range(0, 4)) - 1;
            fetch(d, ra, int'($urandom_range(0, 3)), wc,
                  ($urandom_range(0, 1) == 1) ? ra : rand_addr(d), $urandom, got);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
